// File: rtl/bus_hold_arbiter_if.sv
// Bus hold arbiter signal bundle: DMA hold handshake, CPU bus-cycle status and
// arbiter outputs. The master modport is the arbiter; the slave modport is the system side.
interface bus_hold_arbiter_if;
  // HRQ/HLDA form a four-phase request/acknowledge: the DMA raises HRQ and waits for HLDA.
  // It drives the bus only while HLDA=1, then drops HRQ and must see HLDA fall before
  // requesting again. cpu_busy marks a CPU bus cycle that must complete before hand-off.
  logic       HRQ;
  logic       cpu_busy;
  logic       HLDA;
  logic       cpu_stall;
  logic       cpu_bus_en;
  logic       hold_expire;
  logic [2:0] arb_state;

  modport master (
    input  HRQ,
    input  cpu_busy,
    output HLDA,
    output cpu_stall,
    output cpu_bus_en,
    output hold_expire,
    output arb_state
  );

  modport slave (
    output HRQ,
    output cpu_busy,
    input  HLDA,
    input  cpu_stall,
    input  cpu_bus_en,
    input  hold_expire,
    input  arb_state
  );
endinterface

// File: rtl/bus_hold_arbiter.sv
// Shared-bus arbiter between CPU and DMA: HRQ -> HLDA with turnaround cycles,
// hold-time warning and CPU guard window. Optional counters under BUS_ARB_STATS_EN.
module bus_hold_arbiter #(
  parameter int MAX_HOLD = 64,
  parameter int CPU_MIN  = 4,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                Reset,
  bus_hold_arbiter_if.master  bus
`ifdef BUS_ARB_STATS_EN
  ,
  output logic [15:0]         grant_cnt,
  output logic [15:0]         dma_cycles
`endif
);

  typedef enum logic [2:0] {
    CPU_OWN   = 3'd0,
    WAIT_IDLE = 3'd1,
    SETTLE    = 3'd2,
    DMA_OWN   = 3'd3,
    RELEASE   = 3'd4,
    CPU_GUARD = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LIM  = CNT_W'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);
  localparam logic [CNT_W-1:0] GUARD_LIM = CNT_W'((CPU_MIN > 0) ? (CPU_MIN - 1) : 0);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_hold_cnt;
  logic [CNT_W-1:0] w_hold_cnt_nxt;
  logic [CNT_W-1:0] r_guard_cnt;
  logic [CNT_W-1:0] w_guard_cnt_nxt;

  logic             w_hlda;
  logic             w_stall;
  logic             w_bus_en;
  logic             w_hold_expire;

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state     <= CPU_OWN;
      r_hold_cnt  <= '0;
      r_guard_cnt <= '0;
    end else begin
      r_state     <= w_next_state;
      r_hold_cnt  <= w_hold_cnt_nxt;
      r_guard_cnt <= w_guard_cnt_nxt;
    end
  end

  always_comb begin
    w_next_state    = r_state;
    w_hold_cnt_nxt  = r_hold_cnt;
    w_guard_cnt_nxt = r_guard_cnt;
    case (r_state)
      CPU_OWN: begin
        if (bus.HRQ) w_next_state = WAIT_IDLE;
      end
      WAIT_IDLE: begin
        // A dropped request beats a CPU cycle finishing in the same clock.
        if (!bus.HRQ)          w_next_state = CPU_OWN;
        else if (!bus.cpu_busy) w_next_state = SETTLE;
      end
      SETTLE: begin
        if (!bus.HRQ) begin
          w_next_state = CPU_OWN;
        end else begin
          w_next_state   = DMA_OWN;
          w_hold_cnt_nxt = '0;
        end
      end
      DMA_OWN: begin
        if (!bus.HRQ)                   w_next_state   = RELEASE;
        else if (r_hold_cnt != CNT_MAX) w_hold_cnt_nxt = r_hold_cnt + 1'b1;
      end
      RELEASE: begin
        if (CPU_MIN == 0) begin
          w_next_state = CPU_OWN;
        end else begin
          w_next_state    = CPU_GUARD;
          w_guard_cnt_nxt = '0;
        end
      end
      CPU_GUARD: begin
        // HRQ is deliberately not looked at here; the CPU keeps the bus for CPU_MIN cycles.
        if (r_guard_cnt >= GUARD_LIM) w_next_state    = CPU_OWN;
        else                          w_guard_cnt_nxt = r_guard_cnt + 1'b1;
      end
      default: begin
        w_next_state = CPU_OWN;
      end
    endcase
  end

  always_comb begin
    w_hlda   = 1'b0;
    w_stall  = 1'b0;
    w_bus_en = 1'b1;
    case (r_state)
      CPU_OWN: begin
        w_stall  = 1'b0;
        w_bus_en = 1'b1;
      end
      WAIT_IDLE: begin
        w_stall  = 1'b1;
        w_bus_en = 1'b1;
      end
      SETTLE: begin
        w_stall  = 1'b1;
        w_bus_en = 1'b0;
      end
      DMA_OWN: begin
        w_stall  = 1'b1;
        w_bus_en = 1'b0;
        w_hlda   = 1'b1;
      end
      RELEASE: begin
        w_stall  = 1'b1;
        w_bus_en = 1'b0;
      end
      CPU_GUARD: begin
        w_stall  = 1'b0;
        w_bus_en = 1'b1;
      end
      default: begin
        w_hlda   = 1'b0;
        w_stall  = 1'b0;
        w_bus_en = 1'b1;
      end
    endcase
  end

  // The hold counter reads k-1 during the k-th DMA_OWN cycle.
  assign w_hold_expire = (MAX_HOLD != 0) && (r_state == DMA_OWN) && (r_hold_cnt >= HOLD_LIM);

  assign bus.HLDA        = w_hlda;
  assign bus.cpu_stall   = w_stall;
  assign bus.cpu_bus_en  = w_bus_en;
  assign bus.hold_expire = w_hold_expire;
  assign bus.arb_state   = r_state;

`ifdef BUS_ARB_STATS_EN
  logic [15:0] r_grant_cnt;
  logic [15:0] r_dma_cycles;

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_grant_cnt  <= '0;
      r_dma_cycles <= '0;
    end else begin
      if ((r_state == SETTLE) && (w_next_state == DMA_OWN) && (r_grant_cnt != 16'hFFFF))
        r_grant_cnt <= r_grant_cnt + 16'd1;
      if ((r_state == DMA_OWN) && (r_dma_cycles != 16'hFFFF))
        r_dma_cycles <= r_dma_cycles + 16'd1;
    end
  end

  assign grant_cnt  = r_grant_cnt;
  assign dma_cycles = r_dma_cycles;
`endif

endmodule

// File: tb/tb_bus_hold_arbiter.sv
// Directed bench for bus_hold_arbiter (MAX_HOLD=8, CPU_MIN=4); expected states
// and outputs are hand-derived. Build with BUS_ARB_STATS_EN to cover the counters.
module tb_bus_hold_arbiter;

  logic clk;
  logic Reset;
  int   n_tests;
  int   n_fail;
  logic [2:0] exp_q[$];

  bus_hold_arbiter_if bus_if ();

`ifdef BUS_ARB_STATS_EN
  logic [15:0] grant_cnt;
  logic [15:0] dma_cycles;
`endif

  bus_hold_arbiter #(
    .MAX_HOLD (8),
    .CPU_MIN  (4),
    .CNT_W    (8)
  ) dut (
    .clk        (clk),
    .Reset      (Reset),
    .bus        (bus_if.master)
`ifdef BUS_ARB_STATS_EN
    ,
    .grant_cnt  (grant_cnt),
    .dma_cycles (dma_cycles)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected outputs come from the per-state output table of the arbiter.
  task automatic chk_state(input string tag, input logic [2:0] st, input logic exp_expire);
    logic e_hlda, e_stall, e_en;
    e_hlda  = (st == 3'd3);
    e_stall = !((st == 3'd0) || (st == 3'd5));
    e_en    = (st == 3'd0) || (st == 3'd1) || (st == 3'd5);
    chk({tag, ".state"},  16'(bus_if.arb_state), 16'(st));
    chk({tag, ".hlda"},   16'(bus_if.HLDA), 16'(e_hlda));
    chk({tag, ".stall"},  16'(bus_if.cpu_stall), 16'(e_stall));
    chk({tag, ".bus_en"}, 16'(bus_if.cpu_bus_en), 16'(e_en));
    chk({tag, ".expire"}, 16'(bus_if.hold_expire), 16'(exp_expire));
    chk({tag, ".overlap"}, 16'(bus_if.HLDA & bus_if.cpu_bus_en), 16'd0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    Reset           = 1'b1;
    bus_if.HRQ      = 1'b0;
    bus_if.cpu_busy = 1'b0;
    tick();
    chk_state("reset", 3'd0, 1'b0);
    Reset = 1'b0;
    tick();
    tick();
    chk_state("idle", 3'd0, 1'b0);

    // Fast grant: CPU idle, HLDA two edges after WAIT_IDLE entry.
    bus_if.HRQ = 1'b1;
    tick(); chk_state("grant.e0", 3'd1, 1'b0);
    tick(); chk_state("grant.e1", 3'd2, 1'b0);
    tick(); chk_state("grant.e2", 3'd3, 1'b0);
    // Hold 20 DMA_OWN cycles; hold_expire from the 8th cycle on.
    for (int i = 1; i < 20; i++) begin
      tick();
      chk_state($sformatf("hold.c%0d", i + 1), 3'd3, (i >= 7));
    end

    // Drop then re-raise HRQ: RELEASE, 4x CPU_GUARD, CPU_OWN, WAIT_IDLE, SETTLE, DMA_OWN.
    bus_if.HRQ = 1'b0;
    tick();
    chk_state("rel", 3'd4, 1'b0);
    bus_if.HRQ = 1'b1;
    exp_q = '{3'd5, 3'd5, 3'd5, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3};
    while (exp_q.size() > 0) begin
      logic [2:0] e;
      e = exp_q.pop_front();
      tick();
      chk_state($sformatf("guard.q%0d", exp_q.size()), e, 1'b0);
    end

    // Reset taken from DMA_OWN.
    Reset = 1'b1;
    tick();
    chk_state("rst_dma", 3'd0, 1'b0);
    Reset      = 1'b0;
    bus_if.HRQ = 1'b0;
    tick();
    chk_state("rst_dma.after", 3'd0, 1'b0);
`ifdef BUS_ARB_STATS_EN
    chk("stats.rst_grant", grant_cnt, 16'd0);
    chk("stats.rst_cycles", dma_cycles, 16'd0);
`endif

    // CPU busy for 5 cycles in WAIT_IDLE delays the grant.
    bus_if.HRQ      = 1'b1;
    bus_if.cpu_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_state($sformatf("busy.c%0d", i), 3'd1, 1'b0);
    end
    bus_if.cpu_busy = 1'b0;
    tick(); chk_state("busy.settle", 3'd2, 1'b0);
    tick(); chk_state("busy.dma0", 3'd3, 1'b0);
    tick(); chk_state("busy.dma1", 3'd3, 1'b0);
    tick(); chk_state("busy.dma2", 3'd3, 1'b0);
    bus_if.HRQ = 1'b0;
    tick(); chk_state("busy.rel", 3'd4, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_state($sformatf("busy.guard%0d", i), 3'd5, 1'b0);
    end
    tick(); chk_state("busy.cpu", 3'd0, 1'b0);

    // One-cycle HRQ pulse while CPU busy: abort back to CPU_OWN.
    bus_if.HRQ      = 1'b1;
    bus_if.cpu_busy = 1'b1;
    tick(); chk_state("pulse.wait", 3'd1, 1'b0);
    bus_if.HRQ = 1'b0;
    tick(); chk_state("pulse.abort", 3'd0, 1'b0);

    // HRQ and cpu_busy fall together: abort wins.
    bus_if.HRQ = 1'b1;
    tick(); chk_state("simul.wait", 3'd1, 1'b0);
    bus_if.HRQ      = 1'b0;
    bus_if.cpu_busy = 1'b0;
    tick(); chk_state("simul.abort", 3'd0, 1'b0);

    // Abort from SETTLE.
    bus_if.HRQ = 1'b1;
    tick(); chk_state("sabort.wait", 3'd1, 1'b0);
    tick(); chk_state("sabort.settle", 3'd2, 1'b0);
    bus_if.HRQ = 1'b0;
    tick(); chk_state("sabort.cpu", 3'd0, 1'b0);
    tick(); chk_state("sabort.idle", 3'd0, 1'b0);

`ifdef BUS_ARB_STATS_EN
    chk("stats.grant", grant_cnt, 16'd1);
    chk("stats.cycles", dma_cycles, 16'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
